seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Downstream display stage for the 4-bit adder datapath. It latches a 16-bit value (four hex nibbles, e.g. {3'b0, carry, sum}) on a load strobe and time-multiplexes it onto the Basys3 4-digit common-anode 7-segment display. Updates are double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new data.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is enabled (100 MHz gives 1 kHz per digit, 250 Hz per frame); must be >= 2
DIGITS, 4, number of digits scanned; fixed at 4 and not to be overridden

Ports:
clk  in  1  system clock (Basys3 100 MHz)
rst_n  in  1  synchronous, active-low reset
load  in  1  one-cycle strobe that captures value/dp_in/blank_in
value  in  16  nibble i is shown on digit i (digit 0 is rightmost)
dp_in  in  4  decimal-point request per digit, active high
blank_in  in  4  force digit off, active high
seg  out  7  {g,f,e,d,c,b,a}, active low, registered
dp  out  1  decimal point, active low, registered
an  out  4  digit anodes, active low, registered
frame_tick  out  1  one-cycle pulse on each commit / frame start

Behaviour:
- Reset (rst_n low at a clk edge): prescaler=0, idx=0, active and pending registers=0, pending_valid=0, an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and idx advances by 1 mod 4.
- Commit: occurs when idx wraps 3->0, and also on the first cycle after reset release.
  - frame_tick=1 for that one cycle.
  - If pending_valid, active <= pending and pending_valid is cleared.
- load:
  - Captures inputs into pending and sets pending_valid.
  - Last load wins if several arrive within one frame.
  - A load on the commit cycle bypasses pending and is written straight into active.
- Outputs are registered from the current idx and active registers, i.e. one cycle after the idx change.
  - an = ~(1<<idx), or 4'b1111 if active blank[idx].
  - seg = hex decode of active nibble[idx]; all 1s when blanked.
  - dp = ~active_dp[idx]; 1 when blanked.
- Decode table (gfedcba, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Latency: load to visible takes at most one frame (4*REFRESH_DIV) plus 1 cycle.
- Reset mid-scan: pending data is discarded and scanning restarts at digit 0.
- No X propagation: every register has a reset value.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: digit i (i = 3..1) is auto-blanked when nibble i and every higher nibble are 0. Digit 0 is never auto-blanked. Auto-blank is ORed with blank_in and evaluated on the active registers.
- Undefined: only blank_in blanks digits, and leading zeros are displayed.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F
  - a 16-entry hex-to-segment constant array
  - digit index typedef (2 bits)
- Sub-module hex_to_seg7: purely combinational 4-bit nibble to 7-bit active-low pattern, using the package table. Instantiated once on the muxed nibble.

Test Plan (REFRESH_DIV=4):
- Reset: hold rst_n=0 for 3 cycles -> an=1111, seg=1111111, dp=1. The first cycle after release shows frame_tick=1; one cycle later an=1110, seg=1000000.
- Scan: no load -> an sequence 1110,1101,1011,0111, each held 4 cycles; frame_tick pulses exactly every 16 cycles.
- Mid-frame load: value=16'h1A3F while idx=1 -> outputs unchanged until the next frame_tick. Then digit0 seg=0001110, digit1 seg=0110000, digit2 seg=0001000, digit3 seg=1111001.
- Double load plus bypass: load 16'h1111 then 16'h2222 in one frame -> only 2 is ever shown. Load 16'h0005 on the commit cycle -> digit0 shows 0010010 in the same frame.
- Blank/dp: blank_in=4'b1000, dp_in=4'b0001 -> an[3] never goes low; dp=0 only while an=1110.
- Reset mid-scan at idx=2 with pending_valid=1 -> next edge gives the reset values, and the pending value is never displayed. With SEG7_LEADING_ZERO_BLANK_EN, value=16'h0042 -> digits 3 and 2 stay off.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Indexed by nibble value; the first listed entry lands at index 15.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef logic [1:0] digit_idx_t;

    // One display buffer: nibble i / dp bit i / blank bit i belong to digit i.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern lookup.
import seg7_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered scan driver for a 4-digit common-anode 7-segment display.
// A load lands in a pending buffer and is committed to the active buffer at
// the next frame boundary (idx wrap 3->0, or the first cycle out of reset).
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to auto-blank leading
// zero digits 3..1.
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIGITS      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    digit_idx_t       idx_q, idx_d;
    logic             init_q, init_d;
    disp_t            active_q, active_d;
    disp_t            pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             terminal;
    logic             commit;
    disp_t            load_data;
    logic [3:0]       blank_eff;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;

    assign load_data  = {value, dp_in, blank_in};
    assign frame_tick = commit & rst_n;

    // Prescaler and digit index; the init commit cycle holds the prescaler so
    // digit 0 gets a full REFRESH_DIV of display time after reset.
    always_comb begin
        terminal = (pre_q == PRE_W'(REFRESH_DIV - 1));
        commit   = init_q | (terminal && (idx_q == digit_idx_t'(DIGITS - 1)));
        pre_d    = pre_q;
        idx_d    = idx_q;
        init_d   = 1'b0;
        if (!init_q) begin
            if (terminal) begin
                pre_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Double buffer: loads park in pending, commits move them to active; a
    // load coinciding with a commit goes straight to active.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (commit) begin
            if (load) begin
                active_d = load_data;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_d       = load_data;
            pending_valid_d = 1'b1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Leading-zero suppression on the active buffer; digit 0 always shows.
    always_comb begin
        blank_eff = active_q.blank;
        if (active_q.value[15:12] == 4'h0) blank_eff[3] = 1'b1;
        if (active_q.value[15:8]  == 8'h0) blank_eff[2] = 1'b1;
        if (active_q.value[15:4]  == 12'h0) blank_eff[1] = 1'b1;
    end
`else
    assign blank_eff = active_q.blank;
`endif

    assign nibble = active_q.value[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Next display outputs for the digit currently selected by idx.
    always_comb begin
        if (blank_eff[idx_q]) begin
            an_d  = 4'hF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_dec;
            dp_d  = ~active_q.dp[idx_q];
        end
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q           <= '0;
            idx_q           <= '0;
            init_q          <= 1'b1;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            an_q            <= 4'hF;
            seg_q           <= SEG_BLANK;
            dp_q            <= 1'b1;
        end else begin
            pre_q           <= pre_d;
            idx_q           <= idx_d;
            init_q          <= init_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4. A scoreboard queue
// holds display frames expected after the next commit; each frame_tick pops
// one and the following 16 cycles are checked digit by digit.
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dpm;
        logic [3:0]  blk;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int     n_cmp = 0;
    int     n_bad = 0;
    frame_t exp_q[$];
    frame_t cur, prev;

    seg7_scan_driver #(.REFRESH_DIV(4), .DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Expected {an, seg, dp} while digit d of frame f is on display.
    function automatic logic [11:0] exp_out(input frame_t f, input int d);
        logic [3:0] b;
        logic [3:0] onehot;
        b = f.blk;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < 4; i++)
            if ((f.val >> (4 * i)) == 16'h0) b[i] = 1'b1;
`endif
        onehot = 4'b0001 << d;
        if (b[d]) return {4'hF, 7'h7F, 1'b1};
        return {~onehot, hex7(f.val[4*d +: 4]), ~f.dpm[d]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] bk);
        frame_t f;
        value    = v;
        dp_in    = dpi;
        blank_in = bk;
        load     = 1'b1;
        f = '{val: v, dpm: dpi, blk: bk};
        exp_q.delete();  // last load before a commit wins
        exp_q.push_back(f);
    endtask

    // Reset held three cycles, then released just after a clock edge so the
    // init commit cycle (frame_tick high) is visible at the next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        exp_q.delete();
        cur  = '0;
        prev = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_disp", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
            chk("rst_tick", frame_tick, 1'b0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_tick", frame_tick, 1'b1);
        chk("init_disp", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    endtask

    // Entered at the negedge of a commit cycle. la == 0 loads on the commit
    // cycle itself; la/la2 in 1..15 load mid-frame; rst_at aborts the frame.
    task automatic frame(input bit init, input int la, input int la2,
                         input logic [15:0] v, input logic [15:0] v2,
                         input logic [3:0] dpi, input logic [3:0] bk, input int rst_at);
        int d;
        if (la == 0) drive_load(v, dpi, bk);
        prev = cur;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        for (int o = 1; o <= 16; o++) begin
            @(negedge clk);
            load = 1'b0;
            d = (o == 1) ? (init ? 0 : 3) : (o - 2) / 4;
            chk("disp", {an, seg, dp}, exp_out((o == 1) ? prev : cur, d));
            chk("tick", frame_tick, (o == 16));
            if (o == rst_at) begin
                rst_n = 1'b0;
                return;
            end
            if (o == la)  drive_load(v, dpi, bk);
            if (o == la2) drive_load(v2, dpi, bk);
        end
    endtask

    initial begin
        do_reset();
        // Plain scan of zeros, init frame then a steady frame
        frame(1'b1, -1, -1, 16'h0, 16'h0, 4'h0, 4'h0, -1);
        frame(1'b0, -1, -1, 16'h0, 16'h0, 4'h0, 4'h0, -1);
        // Mid-frame load while idx=1: held until the next commit
        frame(1'b0, 6, -1, 16'h1A3F, 16'h0, 4'h0, 4'h0, -1);
        frame(1'b0, -1, -1, 16'h0, 16'h0, 4'h0, 4'h0, -1);
        // Two loads in one frame: only the second is ever shown
        frame(1'b0, 3, 9, 16'h1111, 16'h2222, 4'h0, 4'h0, -1);
        frame(1'b0, -1, -1, 16'h0, 16'h0, 4'h0, 4'h0, -1);
        // Load on the commit cycle goes straight to active
        frame(1'b0, 0, -1, 16'h0005, 16'h0, 4'h0, 4'h0, -1);
        // Blank digit 3, decimal point on digit 0
        frame(1'b0, 5, -1, 16'h8765, 16'h0, 4'b0001, 4'b1000, -1);
        frame(1'b0, -1, -1, 16'h0, 16'h0, 4'h0, 4'h0, -1);
        // Leading zeros (auto-blanked only with the optional feature)
        frame(1'b0, 0, -1, 16'h0042, 16'h0, 4'h0, 4'h0, -1);
        frame(1'b0, -1, -1, 16'h0, 16'h0, 4'h0, 4'h0, -1);
        // Reset at idx=2 with a pending load: pending is discarded
        frame(1'b0, 3, -1, 16'h1234, 16'h0, 4'h0, 4'h0, 10);
        do_reset();
        frame(1'b1, -1, -1, 16'h0, 16'h0, 4'h0, 4'h0, -1);
        frame(1'b0, -1, -1, 16'h0, 16'h0, 4'h0, 4'h0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
